// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_pkg
//  Description : Shared sizes, types and the round/saturate helper used by the
//                time-multiplexed FIR engine.
//                NTAPS taps, DW-bit unsigned samples, CW-bit Q1.FRAC signed
//                coefficients, ACCW-bit signed accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int NTAPS = 31;
    localparam int DW    = 10;
    localparam int CW    = 32;
    localparam int FRAC  = 30;
    localparam int ACCW  = 48;
    localparam int AW    = 5;              // tap index / coefficient address width
    localparam int PW    = DW + 1 + CW;    // signed product width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } fir_state_t;

    typedef logic        [DW-1:0]   sample_t;
    typedef logic signed [CW-1:0]   coef_t;
    typedef logic signed [ACCW-1:0] acc_t;
    typedef logic        [AW-1:0]   tap_idx_t;

    localparam acc_t SAT_MAX = acc_t'((1 << DW) - 1);

    // Drop the fraction bits (arithmetic shift) and clamp into the unsigned
    // output code range.
    function automatic sample_t round_sat(input acc_t acc);
        acc_t r;
        r = acc >>> FRAC;
        if (r[ACCW-1]) begin
            return '0;
        end else if (r > SAT_MAX) begin
            return '1;
        end else begin
            return sample_t'(r);
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_sample_ring.sv
`default_nettype none
// ============================================================================
//  Module      : fir_sample_ring
//  Description : NTAPS-deep sample history ring. Writes land at the write
//                pointer; the read port returns ring[(wr_ptr - k) mod NTAPS],
//                so k=0 is the newest sample while the pointer is held.
//  Ports       : clk      - clock
//                reset    - synchronous active-low reset (clears ring/pointer)
//                i_we     - write i_wdata at the write pointer
//                i_wdata  - sample to store
//                i_adv    - advance write pointer (wraps NTAPS-1 -> 0)
//                i_k      - tap offset back from the write pointer
//                o_rdata  - sample at (wr_ptr - i_k) mod NTAPS
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_sample_ring
    import fir_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     i_we,
    input  sample_t  i_wdata,
    input  logic     i_adv,
    input  tap_idx_t i_k,
    output sample_t  o_rdata
);

    sample_t  r_mem [NTAPS];
    tap_idx_t r_wr_ptr;
    tap_idx_t w_rd_addr;

    // Modulo-NTAPS subtraction. The wrapped branch may overflow the 5-bit
    // intermediate, but the final value is always below NTAPS.
    always_comb begin
        if (r_wr_ptr >= i_k) begin
            w_rd_addr = r_wr_ptr - i_k;
        end else begin
            w_rd_addr = r_wr_ptr + tap_idx_t'(NTAPS) - i_k;
        end
    end

    assign o_rdata = r_mem[w_rd_addr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NTAPS; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
        end else begin
            if (i_we) begin
                r_mem[r_wr_ptr] <= i_wdata;
            end
            if (i_adv) begin
                r_wr_ptr <= (r_wr_ptr == tap_idx_t'(NTAPS - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fir_mac_sequencer
//  Description : Time-multiplexed FIR controller. One shared multiply-
//                accumulate walks NTAPS taps per sample (NTAPS+2 cycles from
//                accept to result), with a double-banked coefficient store so
//                reloads never disturb an in-flight result.
//  Ports       : clk            - clock, all logic on posedge
//                reset          - synchronous active-low reset
//                sample_valid   - new sample offered
//                sample         - unsigned sample
//                sample_ready   - engine idle, sample will be accepted
//                coef_we        - write coef_wdata to shadow bank at coef_addr
//                coef_addr      - tap index (>= NTAPS ignored)
//                coef_wdata     - Q1.30 signed coefficient
//                coef_commit    - request shadow -> active swap
//                filtered_valid - one-cycle pulse, filtered holds new result
//                filtered       - saturated result, held between pulses
//                busy           - computation in progress
//                overrun        - sticky, sample offered while not ready
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_mac_sequencer
    import fir_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          sample_valid,
    input  logic [DW-1:0] sample,
    output logic          sample_ready,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [CW-1:0] coef_wdata,
    input  logic          coef_commit,
    output logic          filtered_valid,
    output logic [DW-1:0] filtered,
    output logic          busy,
    output logic          overrun
);

    fir_state_t r_state;
    fir_state_t w_next_state;

    tap_idx_t   r_k;
    acc_t       r_acc;
    logic       r_commit_pend;
    sample_t    r_filtered;
    logic       r_overrun;
    coef_t      r_shadow [NTAPS];
    coef_t      r_active [NTAPS];

    logic                 w_accept;
    logic                 w_swap;
    logic                 w_coef_wr;
    sample_t              w_ring_rd;
    logic signed [PW-1:0] w_prod;
    acc_t                 w_prod_ext;

    assign w_accept  = sample_valid & sample_ready;
    assign w_coef_wr = coef_we & (coef_addr < tap_idx_t'(NTAPS));
    // A commit arriving in an IDLE cycle swaps immediately, so a sample
    // accepted in that same cycle already sees the new coefficients.
    assign w_swap    = (r_state == IDLE) & (r_commit_pend | coef_commit);

    fir_sample_ring u_ring (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_accept),
        .i_wdata (sample),
        .i_adv   (r_state == OUT),
        .i_k     (r_k),
        .o_rdata (w_ring_rd)
    );

    // Sample is an unsigned code: prepend a zero so it multiplies as a
    // non-negative signed value.
    assign w_prod     = PW'($signed({1'b0, w_ring_rd})) * PW'(r_active[r_k]);
    assign w_prod_ext = {{(ACCW - PW){w_prod[PW-1]}}, w_prod};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = MAC;
            MAC:     if (r_k == tap_idx_t'(NTAPS - 1)) w_next_state = ROUND;
            ROUND:   w_next_state = OUT;
            OUT:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        sample_ready   = (r_state == IDLE);
        busy           = (r_state != IDLE);
        filtered_valid = (r_state == OUT);
    end

    assign filtered = r_filtered;
    assign overrun  = r_overrun;

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_k           <= '0;
            r_acc         <= '0;
            r_commit_pend <= 1'b0;
            r_filtered    <= '0;
            r_overrun     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_acc <= '0;
                r_k   <= '0;
            end else if (r_state == MAC) begin
                r_acc <= r_acc + w_prod_ext;
                if (r_k != tap_idx_t'(NTAPS - 1)) begin
                    r_k <= r_k + 1'b1;
                end
            end

            // Registered at the end of ROUND so the value is stable for the
            // whole OUT cycle in which filtered_valid pulses.
            if (r_state == ROUND) begin
                r_filtered <= round_sat(r_acc);
            end

            if (sample_valid && !sample_ready) begin
                r_overrun <= 1'b1;
            end

            if (w_swap) begin
                r_commit_pend <= 1'b0;
            end else if (coef_commit) begin
                r_commit_pend <= 1'b1;
            end
        end
    end

    // ---------------- Coefficient banks ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NTAPS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NTAPS; i++) begin
                if (w_coef_wr && (coef_addr == tap_idx_t'(i))) begin
                    r_shadow[i] <= coef_wdata;
                end
                // Same-cycle write is forwarded into the swap.
                if (w_swap) begin
                    r_active[i] <= (w_coef_wr && (coef_addr == tap_idx_t'(i))) ? coef_wdata
                                                                                 : r_shadow[i];
                end
            end
        end
    end

endmodule
`default_nettype wire
